// File: rtl/seq_mult_unit.sv
// ---------------------------------------------------------------------------
// seq_mult_unit
//
// Sequential shift-add multiplier. Each cycle in BUSY adds one partial product
// into a 2*WIDTH accumulator, so a product takes WIDTH cycles regardless of
// operand values. Operands enter over a valid/ready handshake and the product
// leaves over a second valid/ready handshake. Only one operation is in flight
// at a time.
//
// Build option:
//   SEQ_MULT_SIGNED_EN  defined   : op_signed selects two's-complement mode.
//                                   Magnitudes are multiplied and the product
//                                   is negated at the end when the signs
//                                   differ.
//                       undefined : op_signed is ignored. All operands are
//                                   unsigned and no sign logic is built.
//   The port list is the same in both builds.
//
// Parameters:
//   WIDTH  operand width in bits (2..32). The result is 2*WIDTH bits.
//   CNT_W  bit-counter width. It is derived from WIDTH; leave it at default.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operands present
//   in_ready   out  block accepts operands (IDLE only)
//   op_a       in   multiplicand, WIDTH bits
//   op_b       in   multiplier, WIDTH bits
//   op_signed  in   two's-complement operands (signed build only)
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer takes the result
//   result     out  product, 2*WIDTH bits, held until the next completion
//   busy       out  high in BUSY or DONE
// ---------------------------------------------------------------------------
module seq_mult_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic               op_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Count value of the final partial-product cycle.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;       // running sum of partial products
    logic [2*WIDTH-1:0] mcand;     // multiplicand, shifted left once per cycle
    logic [WIDTH-1:0]   mplier;    // multiplier, shifted right once per cycle

    logic [WIDTH-1:0]   mag_a;     // operand magnitudes at the accept edge
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc_next;  // accumulator after this cycle's add
    logic [2*WIDTH-1:0] prod_final;

    // -----------------------------------------------------------------------
    // Operand conditioning and final sign fix-up
    // -----------------------------------------------------------------------
`ifdef SEQ_MULT_SIGNED_EN
    logic neg_in;
    logic neg;     // product must be negated on completion

    // NOTE: every signal driven from always_comb gets a value on every path
    // (here a default first), otherwise synthesis infers a latch.
    always_comb begin
        mag_a  = op_a;
        mag_b  = op_b;
        neg_in = 1'b0;
        if (op_signed) begin
            // The most negative value maps onto itself (e.g. 8'h80 -> 128),
            // and that is the correct unsigned magnitude.
            if (op_a[WIDTH-1]) mag_a = -op_a;
            if (op_b[WIDTH-1]) mag_b = -op_b;
            neg_in = op_a[WIDTH-1] ^ op_b[WIDTH-1];
        end
    end

    // The sign flag is captured with the operands and is cleared by reset
    // like the rest of the datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg <= 1'b0;
        end else if (state == S_IDLE && in_valid) begin
            neg <= neg_in;
        end
    end

    always_comb begin
        prod_final = acc_next;
        if (neg) prod_final = -acc_next;
    end
`else
    // op_signed has no function in the unsigned build.
    logic unused_op_signed;
    assign unused_op_signed = op_signed;

    always_comb begin
        mag_a      = op_a;
        mag_b      = op_b;
        prod_final = acc_next;
    end
`endif

    // One partial product per cycle: add the shifted multiplicand when the
    // current multiplier bit is set.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) acc_next = acc + mcand;
    end

    // -----------------------------------------------------------------------
    // Control FSM and datapath registers, all outputs registered
    // -----------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples values from before the edge and the
    // statement order inside this block does not matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset along with the control
            // state because result must read 0 after reset. The clear costs
            // little, since there is no memory array here.
            state     <= S_IDLE;
            count     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            result    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone
                    // completes the handshake here.
                    if (in_valid) begin
                        mcand    <= {{WIDTH{1'b0}}, mag_a};
                        mplier   <= mag_b;
                        acc      <= '0;
                        count    <= '0;
                        state    <= S_BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                S_BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    // The last partial product goes straight into result, so
                    // out_valid rises exactly WIDTH edges after the accept.
                    if (count == LAST_CNT) begin
                        result    <= prod_final;
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end
                end

                S_DONE: begin
                    // No new operand is taken on this edge. in_ready comes
                    // back only after the return to IDLE.
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_mult_unit
//
// Self-checking bench for seq_mult_unit at WIDTH = 8, 4 and 16. The bench
// builds its expected products from a table of constants and from a plain
// integer-arithmetic model. SEQ_MULT_SIGNED_EN selects the expected
// signed-mode values, so the bench works with either build.
// ---------------------------------------------------------------------------
module tb_seq_mult_unit;

`ifdef SEQ_MULT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    localparam int TIMEOUT = 60;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WIDTH = 8 instance
    logic        iv8, ir8, os8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] r8;
    // WIDTH = 4 instance
    logic        iv4, ir4, os4, ov4, or4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  r4;
    // WIDTH = 16 instance
    logic        iv16, ir16, os16, ov16, or16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] r16;

    seq_mult_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op_a(a8), .op_b(b8),
        .op_signed(os8), .out_valid(ov8), .out_ready(or8), .result(r8), .busy(busy8)
    );
    seq_mult_unit #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .op_a(a4), .op_b(b4),
        .op_signed(os4), .out_valid(ov4), .out_ready(or4), .result(r4), .busy(busy4)
    );
    seq_mult_unit #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .op_a(a16), .op_b(b16),
        .op_signed(os16), .out_valid(ov16), .out_ready(or16), .result(r16), .busy(busy16)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference product: interpret operands as integers (signed only when the
    // signed build is active and s is set), multiply, keep 2*w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic s);
        longint lim, sa, sb;
        lim = longint'(1) << w;
        sa  = longint'(a) & (lim - 1);
        sb  = longint'(b) & (lim - 1);
        if (SIGNED_EN && s) begin
            if (sa >= lim / 2) sa = sa - lim;
            if (sb >= lim / 2) sb = sb - lim;
        end
        return 64'(sa * sb) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full W=8 transaction: accept, then latency, result, optional
    // backpressure and the single-cycle DONE check.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] exp, input int stall, input string name);
        int n;
        or8 = (stall == 0);
        check({name, "_in_ready"}, 64'(ir8), 64'd1);
        iv8 = 1'b1; a8 = a; b8 = b; os8 = s;
        tick();                                   // accept edge E0
        iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); os8 = 1'($urandom);
        n = 0;
        while (!ov8 && n < TIMEOUT) begin
            tick();
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'd8);
        check({name, "_result"}, 64'(r8), 64'(exp));
        for (int i = 0; i < stall; i++) begin
            tick();
            check({name, "_stall_result"}, 64'(r8), 64'(exp));
            check({name, "_stall_in_ready"}, 64'(ir8), 64'd0);
        end
        or8 = 1'b1;
        tick();
        check({name, "_valid_drop"}, 64'(ov8), 64'd0);
        check({name, "_ready_back"}, 64'(ir8), 64'd1);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input logic [7:0] exp, input string name);
        int n;
        or4 = 1'b1;
        iv4 = 1'b1; a4 = a; b4 = b; os4 = s;
        tick();
        iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        n = 0;
        while (!ov4 && n < TIMEOUT) begin
            tick();
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'd4);
        check({name, "_result"}, 64'(r4), 64'(exp));
        tick();
        check({name, "_valid_drop"}, 64'(ov4), 64'd0);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [31:0] exp, input string name);
        int n;
        or16 = 1'b1;
        iv16 = 1'b1; a16 = a; b16 = b; os16 = s;
        tick();
        iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        n = 0;
        while (!ov16 && n < TIMEOUT) begin
            tick();
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'd16);
        check({name, "_result"}, 64'(r16), 64'(exp));
        tick();
        check({name, "_valid_drop"}, 64'(ov16), 64'd0);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
        int          stall;
        string       name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [63:0] m;
        logic [7:0]  ra, rb;
        logic        rs;
        int          n;

        rst = 1'b1;
        iv8 = 0; a8 = 0; b8 = 0; os8 = 0; or8 = 1;
        iv4 = 0; a4 = 0; b4 = 0; os4 = 0; or4 = 1;
        iv16 = 0; a16 = 0; b16 = 0; os16 = 0; or16 = 1;

        vecs.push_back('{8'd13,  8'd11,  1'b0, 16'h008F, 0, "u13x11"});
        vecs.push_back('{8'd255, 8'd255, 1'b0, 16'hFE01, 0, "u255x255"});
        vecs.push_back('{8'd0,   8'd200, 1'b0, 16'h0000, 0, "u0x200"});
        vecs.push_back('{8'd253, 8'd5,   1'b1, SIGNED_EN ? 16'hFFF1 : 16'h04F1, 0, "s_m3x5"});
        vecs.push_back('{8'd128, 8'd128, 1'b1, 16'h4000, 0, "s_m128xm128"});
        vecs.push_back('{8'd128, 8'd127, 1'b1, SIGNED_EN ? 16'hC080 : 16'h3F80, 0, "s_m128x127"});
        vecs.push_back('{8'd253, 8'd5,   1'b0, 16'h04F1, 0, "u253x5"});
        vecs.push_back('{8'd6,   8'd7,   1'b0, 16'h002A, 2, "u6x7_stall"});
        vecs.push_back('{8'd255, 8'd1,   1'b1, SIGNED_EN ? 16'hFFFF : 16'h00FF, 1, "s_m1x1_stall"});

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_in_ready8", 64'(ir8), 64'd1);
        check("rst_out_valid8", 64'(ov8), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_result8", 64'(r8), 64'd0);
        check("rst_in_ready4", 64'(ir4), 64'd1);
        check("rst_result16", 64'(r16), 64'd0);

        // Directed table
        foreach (vecs[i]) begin
            run8(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, vecs[i].stall, vecs[i].name);
        end

        // Backpressure: out_ready low for 5 cycles, new operands offered meanwhile
        or8 = 1'b0;
        iv8 = 1'b1; a8 = 8'd13; b8 = 8'd11; os8 = 1'b0;
        tick();
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < TIMEOUT) begin
            tick();
            n++;
        end
        check("bp_latency", 64'(n), 64'd8);
        for (int i = 0; i < 5; i++) begin
            iv8 = 1'b1; a8 = 8'd99; b8 = 8'd99;
            check("bp_result", 64'(r8), 64'h008F);
            check("bp_in_ready", 64'(ir8), 64'd0);
            check("bp_busy", 64'(busy8), 64'd1);
            check("bp_out_valid", 64'(ov8), 64'd1);
            tick();
        end
        or8 = 1'b1;                               // in_valid still high
        check("bp_deliver_valid", 64'(ov8), 64'd1);
        tick();
        check("bp_after_valid", 64'(ov8), 64'd0);
        check("bp_after_in_ready", 64'(ir8), 64'd1);
        check("bp_after_busy", 64'(busy8), 64'd0);
        check("bp_after_result", 64'(r8), 64'h008F);
        iv8 = 1'b0;
        tick();
        check("bp_no_accept", 64'(busy8), 64'd0);

        // Reset during BUSY at count 3
        or8 = 1'b1;
        iv8 = 1'b1; a8 = 8'd200; b8 = 8'd3; os8 = 1'b0;
        tick();
        iv8 = 1'b0;
        repeat (3) tick();
        check("mid_busy", 64'(busy8), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_out_valid", 64'(ov8), 64'd0);
        check("mid_rst_in_ready", 64'(ir8), 64'd1);
        check("mid_rst_result", 64'(r8), 64'd0);
        check("mid_rst_busy", 64'(busy8), 64'd0);
        run8(8'd6, 8'd7, 1'b0, 16'h002A, 0, "post_rst_6x7");

        // Random W=8 against the model, with random backpressure
        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            m = ref_mul(8, {24'd0, ra}, {24'd0, rb}, rs);
            run8(ra, rb, rs, m[15:0], int'($urandom_range(0, 2)), "rnd8");
        end

        // W=4 sweep
        run4(4'd15, 4'd15, 1'b0, 8'hE1, "w4_15x15");
        for (int i = 0; i < 30; i++) begin
            logic [3:0] qa, qb;
            logic       qs;
            qa = 4'($urandom); qb = 4'($urandom); qs = 1'($urandom);
            m = ref_mul(4, {28'd0, qa}, {28'd0, qb}, qs);
            run4(qa, qb, qs, m[7:0], "rnd4");
        end

        // W=16 sweep
        run16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16_max");
        for (int i = 0; i < 10; i++) begin
            logic [15:0] wa, wb;
            logic        ws;
            wa = 16'($urandom); wb = 16'($urandom); ws = 1'($urandom);
            m = ref_mul(16, {16'd0, wa}, {16'd0, wb}, ws);
            run16(wa, wb, ws, m[31:0], "rnd16");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
